ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-ported, change-detecting word RAM. It serialises read/write requests from two clients (for example, cache line fill and write-through paths) onto the RAM's address/data/mode inputs. It tracks the RAM's busy `response` handshake and returns one `ack` pulse per accepted request. It also guarantees that every issued operation presents a detectable input change to the RAM, and it bounds each transaction with a timeout.

---
 rtl/ram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin arbiter and sequencer for the change-detecting word RAM
module ram_port_arbiter #(
    parameter int ADDR_LSB_W = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        mode0,
    input  logic        mode1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_mode,
    input  logic        ram_response,
    input  logic [31:0] ram_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic             gnt, gnt_nx;
    logic             last_grant, last_grant_nx;
    logic             first_cyc, first_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      ram_address_nx, ram_data_nx, rdata_nx;
    logic             ram_mode_nx, ack0_nx, ack1_nx, err_nx;

    logic             pick, sel_mode, skip_hit, complete, timed_out;
    logic [31:0]      sel_addr, sel_wdata;

    // Requester selection and the "RAM already holds this" write detection.
    always_comb begin
        pick      = (req0 && req1) ? ~last_grant : req1;
        sel_mode  = pick ? mode1  : mode0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
        skip_hit  = sel_mode && ram_mode
                    && (sel_addr[ADDR_LSB_W-1:0] == ram_address[ADDR_LSB_W-1:0])
                    && (sel_wdata == ram_data);
    end

    always_comb begin
        state_nx       = state;
        gnt_nx         = gnt;
        last_grant_nx  = last_grant;
        first_nx       = first_cyc;
        cnt_nx         = cnt;
        ram_address_nx = ram_address;
        ram_data_nx    = ram_data;
        ram_mode_nx    = ram_mode;
        rdata_nx       = rdata;
        ack0_nx        = 1'b0;
        ack1_nx        = 1'b0;
        err_nx         = 1'b0;
        complete       = 1'b0;
        timed_out      = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_nx   = pick;
                    cnt_nx   = '0;
                    first_nx = 1'b1;
                    if (skip_hit) begin
                        state_nx = DONE;
                    end else begin
                        ram_address_nx = sel_addr;
                        ram_mode_nx    = sel_mode;
                        // Reads invert the data lines so even a repeated read is seen as a change.
                        ram_data_nx    = sel_mode ? sel_wdata : ~ram_data;
                        state_nx       = ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
                first_nx = 1'b0;
                if (state == WAIT && !ram_response) begin
                    complete = 1'b1;
                    if (!ram_mode) begin
                        rdata_nx = ram_out;
                    end
                end else if (cnt == CNT_LAST) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    // The first ISSUE cycle may still see busy left over from a previous access.
                    if (state == ISSUE && !first_cyc && ram_response) begin
                        state_nx = WAIT;
                    end
                end
            end
            DONE: begin
                complete = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (complete) begin
            state_nx      = IDLE;
            ack0_nx       = ~gnt;
            ack1_nx       = gnt;
            err_nx        = timed_out;
            last_grant_nx = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_grant  <= 1'b1;
            first_cyc   <= 1'b0;
            cnt         <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_mode    <= 1'b0;
            rdata       <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            gnt         <= gnt_nx;
            last_grant  <= last_grant_nx;
            first_cyc   <= first_nx;
            cnt         <= cnt_nx;
            ram_address <= ram_address_nx;
            ram_data    <= ram_data_nx;
            ram_mode    <= ram_mode_nx;
            rdata       <= rdata_nx;
            ack0        <= ack0_nx;
            ack1        <= ack1_nx;
            err         <= err_nx;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a change-detecting RAM stub
module tb_ram_port_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, ram_mode, ram_response;
    logic [31:0] rdata, ram_address, ram_data, ram_out;
    logic        kill = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(.ADDR_LSB_W(12), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_mode(ram_mode),
        .ram_response(ram_response), .ram_out(ram_out)
    );

    // RAM stub: latches a changed input set, is busy one cycle, then performs the access.
    logic [31:0] ram_mem [0:4095];
    logic        mem_ready = 1'b0, busy = 1'b0, prev_m = 1'b0, lat_m = 1'b0;
    logic [31:0] prev_a = '0, prev_d = '0, lat_a = '0, lat_d = '0, ram_out_r = '0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (busy) begin
            if (lat_m) ram_mem[lat_a[11:0]] <= lat_d;
            else       ram_out_r <= ram_mem[lat_a[11:0]];
            busy <= 1'b0;
        end else if (ram_address != prev_a || ram_data != prev_d || ram_mode != prev_m) begin
            busy   <= 1'b1;
            lat_a  <= ram_address;
            lat_d  <= ram_data;
            lat_m  <= ram_mode;
            prev_a <= ram_address;
            prev_d <= ram_data;
            prev_m <= ram_mode;
        end
    end

    assign ram_response = busy & ~kill;
    assign ram_out      = ram_out_r;

    typedef struct {
        bit          port;
        int          ack_cyc;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] ra;
        logic [31:0] rd;
        bit          rm;
    } exp_t;

    typedef struct {
        bit          mode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    exp_t sbq[$];

    // Reference model: the last input set presented to the RAM, RAM contents, held rdata, last grant.
    logic [31:0] m_a = '0, m_d = '0, m_rdata = '0;
    bit          m_m = 1'b0, m_last = 1'b1;
    logic [31:0] ref_mem [int];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic txn_t mk(input bit mode, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.mode = mode; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic void model_reset();
        m_a = '0; m_d = '0; m_m = 1'b0; m_rdata = '0; m_last = 1'b1;
    endfunction

    function automatic void model_txn(input bit port, input txn_t t, input bit tmo, inout int g);
        exp_t e;
        int   key;
        key   = int'(t.addr[11:0]);
        e.err = 1'b0;
        if (t.mode && m_m && t.addr[11:0] == m_a[11:0] && t.wdata == m_d) begin
            e.ack_cyc = g + 1;
        end else if (t.mode) begin
            m_a = t.addr; m_d = t.wdata; m_m = 1'b1;
            ref_mem[key] = t.wdata;
            e.ack_cyc = g + 3;
        end else begin
            m_a = t.addr; m_d = ~m_d; m_m = 1'b0;
            if (tmo) begin
                e.err = 1'b1;
                e.ack_cyc = g + TMO;
            end else begin
                m_rdata = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
                e.ack_cyc = g + 3;
            end
        end
        e.port = port; e.rdata = m_rdata; e.ra = m_a; e.rd = m_d; e.rm = m_m;
        sbq.push_back(e);
        m_last = port;
        g = e.ack_cyc + 1;
    endfunction

    // Drops each req on its ack and returns once both ports are idle.
    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (!req0 && !req1) break;
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        if (req0 || req1) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: requests still pending req0=%0b req1=%0b", req0, req1);
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic issue(input bit v0, input txn_t t0, input bit v1, input txn_t t1, input bit tmo);
        int g;
        wait_idle();
        @(posedge clk);
        #1;
        g = cyc + 1;
        if (v0) begin req0 = 1'b1; mode0 = t0.mode; addr0 = t0.addr; wdata0 = t0.wdata; end
        if (v1) begin req1 = 1'b1; mode1 = t1.mode; addr1 = t1.addr; wdata1 = t1.wdata; end
        if (v0 && v1) begin
            if (m_last) begin model_txn(1'b0, t0, tmo, g); model_txn(1'b1, t1, tmo, g); end
            else        begin model_txn(1'b1, t1, tmo, g); model_txn(1'b0, t0, tmo, g); end
        end else if (v0) begin
            model_txn(1'b0, t0, tmo, g);
        end else if (v1) begin
            model_txn(1'b1, t1, tmo, g);
        end
    endtask

    function automatic txn_t rand_txn();
        logic [31:0] a, d;
        a = (32'($urandom_range(0, 1)) << 20) | 32'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
            0:       d = 32'h12;
            1:       d = 32'h34;
            default: d = $urandom;
        endcase
        return mk(1'($urandom_range(0, 1)), a, d);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 32'h0);
        chk({tag, "_ack1"}, 32'(ack1), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_ram_address"}, ram_address, 32'h0);
        chk({tag, "_ram_data"}, ram_data, 32'h0);
        chk({tag, "_ram_mode"}, 32'(ram_mode), 32'h0);
    endtask

    // Monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk("dual_ack", 32'(ack0 & ack1), 32'h0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", {30'h0, ack1, ack0}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_port", 32'(ack1), 32'(e.port));
                    chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("ram_address", ram_address, e.ra);
                    chk("ram_data", ram_data, e.rd);
                    chk("ram_mode", 32'(ram_mode), 32'(e.rm));
                end
            end else begin
                if (err) chk("err_without_ack", 32'(err), 32'h0);
            end
        end
    end

    txn_t nop;

    initial begin
        nop = mk(1'b0, 32'h0, 32'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Preload RAM[5], then single read.
        issue(1'b1, mk(1'b1, 32'd5, 32'hDEADBEEF), 1'b0, nop, 1'b0);
        issue(1'b1, mk(1'b0, 32'd5, 32'h0), 1'b0, nop, 1'b0);

        // Ties alternate between ports.
        issue(1'b1, mk(1'b1, 32'd10, 32'hA0A0_0001), 1'b1, mk(1'b1, 32'd11, 32'hB0B0_0002), 1'b0);
        issue(1'b1, mk(1'b1, 32'd10, 32'hA0A0_0003), 1'b1, mk(1'b1, 32'd11, 32'hB0B0_0004), 1'b0);

        // Repeated identical write takes the skip-hit path, then read back.
        issue(1'b0, nop, 1'b1, mk(1'b1, 32'd7, 32'h12), 1'b0);
        issue(1'b0, nop, 1'b1, mk(1'b1, 32'd7, 32'h12), 1'b0);
        issue(1'b0, nop, 1'b1, mk(1'b0, 32'd7, 32'h0), 1'b0);

        // Repeated identical read.
        issue(1'b1, mk(1'b0, 32'd5, 32'h0), 1'b0, nop, 1'b0);
        issue(1'b1, mk(1'b0, 32'd5, 32'h0), 1'b0, nop, 1'b0);

        // Timeout: RAM never reports busy.
        wait_idle();
        kill = 1'b1;
        issue(1'b1, mk(1'b0, 32'd9, 32'h0), 1'b0, nop, 1'b1);
        wait_idle();
        kill = 1'b0;

        // Reset while in WAIT: outputs clear immediately and no ack appears.
        wait_idle();
        @(posedge clk);
        #1;
        req0 = 1'b1; mode0 = 1'b0; addr0 = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        issue(1'b1, mk(1'b0, 32'd5, 32'h0), 1'b0, nop, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       issue(1'b1, rand_txn(), 1'b0, nop, 1'b0);
                1:       issue(1'b0, nop, 1'b1, rand_txn(), 1'b0);
                default: issue(1'b1, rand_txn(), 1'b1, rand_txn(), 1'b0);
            endcase
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
